// File: rtl/retire_trace_buffer.sv
`default_nettype none
// ============================================================================
// Module      : retire_trace_buffer
// Description : Retirement monitor. Samples writeback/memory-stage retirement
//               signals, packs one 72-bit record per active cycle into a FIFO
//               drained over a valid/ready port, and keeps cycle, instruction
//               and drop counters plus halt/timeout completion status.
// Revision    : 1.0 - initial release
// ============================================================================
module retire_trace_buffer #(
  parameter int DEPTH      = 16,
  parameter int MAX_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] pc,
  input  logic        reg_write,
  input  logic [3:0]  dest_reg,
  input  logic [15:0] reg_value,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [15:0] mem_addr,
  input  logic [15:0] mem_data,
  input  logic        hlt,
  output logic        trace_valid,
  input  logic        trace_ready,
  output logic [71:0] trace_data,
  output logic [31:0] cycle_count,
  output logic [31:0] inst_count,
  output logic [15:0] drop_count,
  output logic        overflow,
  output logic        timeout,
  output logic        done
);

  localparam int          c_ADDR_W     = $clog2(DEPTH);
  localparam int          c_PTR_W      = c_ADDR_W + 1;
  localparam int          c_REC_W      = 72;
  localparam logic [31:0] c_LAST_CYCLE = 32'(MAX_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_stateNext;
  logic                 w_timeoutHit;

  logic [c_REC_W-1:0]   r_mem [DEPTH];
  logic [c_PTR_W-1:0]   r_wrPtr;
  logic [c_PTR_W-1:0]   r_rdPtr;
  logic [31:0]          r_cycleCount;
  logic [31:0]          r_instCount;
  logic [15:0]          r_dropCount;
  logic                 r_overflow;
  logic                 r_timeout;

  logic                 w_empty;
  logic                 w_full;
  logic                 w_event;
  logic                 w_pop;
  logic                 w_push;
  logic                 w_drop;
  logic                 w_running;
  logic [c_REC_W-1:0]   w_record;

  // Same index with differing wrap bit means every slot is occupied.
  assign w_empty   = (r_wrPtr == r_rdPtr);
  assign w_full    = (r_wrPtr[c_ADDR_W] != r_rdPtr[c_ADDR_W]) &&
                     (r_wrPtr[c_ADDR_W-1:0] == r_rdPtr[c_ADDR_W-1:0]);

  assign w_running = (r_state == ST_RUN);
  assign w_event   = w_running && (reg_write || mem_read || mem_write || hlt);

  // A pop in the same cycle frees the head slot, so a full FIFO still accepts.
  assign w_pop     = trace_valid && trace_ready;
  assign w_push    = w_event && (!w_full || w_pop);
  assign w_drop    = w_event && w_full && !w_pop;

  assign w_record  = {hlt, reg_write, mem_read, mem_write, dest_reg,
                      reg_value, mem_addr, mem_data, pc};

  // Head of the FIFO comes straight out of the storage flops; zero when idle.
  assign trace_valid = !w_empty && (r_state != ST_DONE);
  assign trace_data  = trace_valid ? r_mem[r_rdPtr[c_ADDR_W-1:0]] : '0;

  assign cycle_count = r_cycleCount;
  assign inst_count  = r_instCount;
  assign drop_count  = r_dropCount;
  assign overflow    = r_overflow;
  assign timeout     = r_timeout;
  assign done        = (r_state == ST_DONE);

  // Record storage; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wrPtr[c_ADDR_W-1:0]] <= w_record;
    end
  end

  // FIFO read/write pointers; reset discards any queued records.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_pop)  r_rdPtr <= r_rdPtr + 1'b1;
    end
  end

  // Cycle and retired-instruction counters advance only while running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cycleCount <= '0;
      r_instCount  <= '0;
    end else if (w_running) begin
      r_cycleCount <= r_cycleCount + 32'd1;
      if (hlt || reg_write || mem_write) begin
        r_instCount <= r_instCount + 32'd1;
      end
    end
  end

  // Overflow bookkeeping: sticky flag plus a saturating drop counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dropCount <= '0;
      r_overflow  <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (r_dropCount != 16'hFFFF) begin
        r_dropCount <= r_dropCount + 16'd1;
      end
    end
  end

  // Sticky timeout flag raised when the run limit ends the run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timeout <= 1'b0;
    end else if (w_timeoutHit) begin
      r_timeout <= 1'b1;
    end
  end

  // Run-state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next state: halt wins over the cycle limit when both land together.
  always_comb begin
    w_stateNext  = r_state;
    w_timeoutHit = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (hlt) begin
          w_stateNext = ST_DRAIN;
        end else if (r_cycleCount == c_LAST_CYCLE) begin
          w_stateNext  = ST_DRAIN;
          w_timeoutHit = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (w_empty) begin
          w_stateNext = ST_DONE;
        end
      end
      ST_DONE: begin
        w_stateNext = ST_DONE;
      end
      default: begin
        w_stateNext = ST_RUN;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_retire_trace_buffer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_retire_trace_buffer
// Description : Directed self-checking bench for retire_trace_buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_retire_trace_buffer;

  localparam int DEPTH      = 16;
  localparam int MAX_CYCLES = 50;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] pc;
  logic        reg_write;
  logic [3:0]  dest_reg;
  logic [15:0] reg_value;
  logic        mem_read;
  logic        mem_write;
  logic [15:0] mem_addr;
  logic [15:0] mem_data;
  logic        hlt;
  logic        trace_valid;
  logic        trace_ready;
  logic [71:0] trace_data;
  logic [31:0] cycle_count;
  logic [31:0] inst_count;
  logic [15:0] drop_count;
  logic        overflow;
  logic        timeout;
  logic        done;

  int errors = 0;
  int checks = 0;

  retire_trace_buffer #(
    .DEPTH      (DEPTH),
    .MAX_CYCLES (MAX_CYCLES)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pc          (pc),
    .reg_write   (reg_write),
    .dest_reg    (dest_reg),
    .reg_value   (reg_value),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_addr    (mem_addr),
    .mem_data    (mem_data),
    .hlt         (hlt),
    .trace_valid (trace_valid),
    .trace_ready (trace_ready),
    .trace_data  (trace_data),
    .cycle_count (cycle_count),
    .inst_count  (inst_count),
    .drop_count  (drop_count),
    .overflow    (overflow),
    .timeout     (timeout),
    .done        (done)
  );

  always #5 clk = ~clk;

  function automatic logic [71:0] mkRec(input logic h, input logic rw, input logic mr,
                                        input logic mw, input logic [3:0] d,
                                        input logic [15:0] rv, input logic [15:0] ma,
                                        input logic [15:0] md, input logic [15:0] p);
    return {h, rw, mr, mw, d, rv, ma, md, p};
  endfunction

  // Expected record for the numbered register-write streams.
  function automatic logic [71:0] seqRec(input int i);
    logic [15:0] v;
    logic [15:0] p;
    logic [3:0]  d;
    v = 16'h1000 + 16'(i);
    p = 16'h0200 + 16'(i);
    d = 4'(i);
    return mkRec(1'b0, 1'b1, 1'b0, 1'b0, d, v, 16'h0000, 16'h0000, p);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    pc = '0; reg_write = 0; dest_reg = '0; reg_value = '0;
    mem_read = 0; mem_write = 0; mem_addr = '0; mem_data = '0; hlt = 0;
  endtask

  // Hold reset for two edges, release just after an edge: next edge is cycle 1.
  task automatic doReset();
    rst_n = 1'b0;
    clearInputs();
    trace_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic pushSeq(input int i);
    reg_write = 1'b1;
    dest_reg  = 4'(i);
    reg_value = 16'h1000 + 16'(i);
    pc        = 16'h0200 + 16'(i);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clearInputs();
    trace_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({trace_valid, trace_data, cycle_count, inst_count, drop_count, overflow, timeout, done} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%0b d=%h cyc=%0d inst=%0d drop=%0d ov=%0b to=%0b done=%0b want all 0",
               trace_valid, trace_data, cycle_count, inst_count, drop_count, overflow, timeout, done);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [71:0] e1;
    logic [71:0] e2;
    e1 = mkRec(0, 1, 0, 0, 4'd1, 16'h0011, 16'h0000, 16'h0000, 16'h0100);
    e2 = mkRec(0, 1, 0, 0, 4'd2, 16'h0022, 16'h0000, 16'h0000, 16'h0102);
    doReset();
    trace_ready = 1'b1;
    tick(); tick();
    reg_write = 1; dest_reg = 4'd1; reg_value = 16'h0011; pc = 16'h0100;
    tick();
    checks++;
    if (trace_valid !== 1'b1 || trace_data !== e1) begin
      errors++; $display("FAIL basic_rec1: got v=%0b %h want v=1 %h", trace_valid, trace_data, e1);
    end
    dest_reg = 4'd2; reg_value = 16'h0022; pc = 16'h0102;
    tick();
    checks++;
    if (trace_valid !== 1'b1 || trace_data !== e2) begin
      errors++; $display("FAIL basic_rec2: got v=%0b %h want v=1 %h", trace_valid, trace_data, e2);
    end
    clearInputs();
    tick();
    checks++;
    if (trace_valid !== 1'b0) begin
      errors++; $display("FAIL basic_empty: got v=%0b want 0", trace_valid);
    end
    checks++;
    if (inst_count !== 32'd2 || cycle_count !== 32'd5) begin
      errors++; $display("FAIL basic_counts: got inst=%0d cyc=%0d want inst=2 cyc=5", inst_count, cycle_count);
    end
  endtask

  task automatic test_overflow();
    logic [71:0] held;
    doReset();
    for (int i = 1; i <= 20; i++) begin
      pushSeq(i);
      tick();
    end
    clearInputs();
    tick();
    checks++;
    if (overflow !== 1'b1 || drop_count !== 16'd4 || inst_count !== 32'd20) begin
      errors++; $display("FAIL ovf_flags: got ov=%0b drop=%0d inst=%0d want ov=1 drop=4 inst=20",
                         overflow, drop_count, inst_count);
    end
    held = trace_data;
    tick();
    checks++;
    if (trace_valid !== 1'b1 || trace_data !== seqRec(1) || trace_data !== held) begin
      errors++; $display("FAIL ovf_stable: got v=%0b %h want v=1 %h", trace_valid, trace_data, seqRec(1));
    end
    trace_ready = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      checks++;
      if (trace_valid !== 1'b1 || trace_data !== seqRec(k)) begin
        errors++; $display("FAIL ovf_drain_%0d: got v=%0b %h want v=1 %h", k, trace_valid, trace_data, seqRec(k));
      end
      tick();
    end
    checks++;
    if (trace_valid !== 1'b0) begin
      errors++; $display("FAIL ovf_after_drain: got v=%0b want 0", trace_valid);
    end
  endtask

  task automatic test_full_push_pop();
    int n;
    logic [71:0] last;
    doReset();
    for (int i = 1; i <= 16; i++) begin
      pushSeq(i);
      tick();
    end
    pushSeq(17);
    trace_ready = 1'b1;
    tick();
    checks++;
    if (drop_count !== 16'd0 || overflow !== 1'b0 || trace_data !== seqRec(2)) begin
      errors++; $display("FAIL fullpp_nodrop: got drop=%0d ov=%0b %h want drop=0 ov=0 %h",
                         drop_count, overflow, trace_data, seqRec(2));
    end
    clearInputs();
    n = 0;
    last = '0;
    while (trace_valid && n < 40) begin
      last = trace_data;
      n++;
      tick();
    end
    checks++;
    if (n !== 16 || last !== seqRec(17)) begin
      errors++; $display("FAIL fullpp_occupancy: got %0d pops last %h want 16 pops last %h", n, last, seqRec(17));
    end
  endtask

  task automatic test_store_and_reg();
    logic [71:0] e;
    e = mkRec(0, 1, 0, 1, 4'd3, 16'h1234, 16'h0040, 16'hBEEF, 16'h0300);
    doReset();
    trace_ready = 1'b1;
    tick();
    reg_write = 1; dest_reg = 4'd3; reg_value = 16'h1234;
    mem_write = 1; mem_addr = 16'h0040; mem_data = 16'hBEEF; pc = 16'h0300;
    tick();
    checks++;
    if (trace_valid !== 1'b1 || trace_data !== e || inst_count !== 32'd1) begin
      errors++; $display("FAIL store_rec: got v=%0b %h inst=%0d want v=1 %h inst=1",
                         trace_valid, trace_data, inst_count, e);
    end
    clearInputs();
    tick();
    checks++;
    if (trace_valid !== 1'b0 || inst_count !== 32'd1) begin
      errors++; $display("FAIL store_single: got v=%0b inst=%0d want v=0 inst=1", trace_valid, inst_count);
    end
  endtask

  task automatic test_halt();
    logic [71:0] e8;
    logic [71:0] e9;
    logic [71:0] eh;
    int guard;
    e8 = mkRec(0, 1, 0, 0, 4'd4, 16'h0444, 16'h0000, 16'h0000, 16'h0400);
    e9 = mkRec(0, 1, 1, 0, 4'd5, 16'h5555, 16'h0050, 16'h5555, 16'h0402);
    eh = mkRec(1, 0, 0, 0, 4'd0, 16'h0000, 16'h0000, 16'h0000, 16'h0404);
    doReset();
    trace_ready = 1'b1;
    repeat (7) tick();
    reg_write = 1; dest_reg = 4'd4; reg_value = 16'h0444; pc = 16'h0400;
    tick();
    checks++;
    if (trace_data !== e8) begin
      errors++; $display("FAIL halt_rec8: got %h want %h", trace_data, e8);
    end
    mem_read = 1; mem_addr = 16'h0050; mem_data = 16'h5555;
    dest_reg = 4'd5; reg_value = 16'h5555; pc = 16'h0402;
    tick();
    checks++;
    if (trace_data !== e9) begin
      errors++; $display("FAIL halt_rec9: got %h want %h", trace_data, e9);
    end
    clearInputs();
    hlt = 1; pc = 16'h0404;
    tick();
    checks++;
    if (trace_data !== eh || cycle_count !== 32'd10 || done !== 1'b0 || inst_count !== 32'd3) begin
      errors++; $display("FAIL halt_rec: got %h cyc=%0d done=%0b inst=%0d want %h cyc=10 done=0 inst=3",
                         trace_data, cycle_count, done, inst_count, eh);
    end
    clearInputs();
    reg_write = 1; dest_reg = 4'd7; reg_value = 16'h7777;
    guard = 0;
    while (!done && guard < 10) begin
      tick();
      guard++;
    end
    checks++;
    if (done !== 1'b1 || trace_valid !== 1'b0 || cycle_count !== 32'd10 || inst_count !== 32'd3) begin
      errors++; $display("FAIL halt_done: got done=%0b v=%0b cyc=%0d inst=%0d want done=1 v=0 cyc=10 inst=3",
                         done, trace_valid, cycle_count, inst_count);
    end
    clearInputs();
  endtask

  task automatic test_timeout();
    logic [71:0] e;
    int guard;
    e = mkRec(0, 1, 0, 0, 4'd6, 16'h0666, 16'h0000, 16'h0000, 16'h0600);
    doReset();
    trace_ready = 1'b1;
    repeat (49) tick();
    checks++;
    if (timeout !== 1'b0 || cycle_count !== 32'd49) begin
      errors++; $display("FAIL to_before: got to=%0b cyc=%0d want to=0 cyc=49", timeout, cycle_count);
    end
    reg_write = 1; dest_reg = 4'd6; reg_value = 16'h0666; pc = 16'h0600;
    trace_ready = 1'b0;
    tick();
    checks++;
    if (timeout !== 1'b1 || cycle_count !== 32'd50 || trace_valid !== 1'b1 || trace_data !== e) begin
      errors++; $display("FAIL to_hit: got to=%0b cyc=%0d v=%0b %h want to=1 cyc=50 v=1 %h",
                         timeout, cycle_count, trace_valid, trace_data, e);
    end
    clearInputs();
    reg_write = 1;
    tick(); tick();
    checks++;
    if (done !== 1'b0 || cycle_count !== 32'd50 || trace_valid !== 1'b1 || inst_count !== 32'd1) begin
      errors++; $display("FAIL to_drain: got done=%0b cyc=%0d v=%0b inst=%0d want done=0 cyc=50 v=1 inst=1",
                         done, cycle_count, trace_valid, inst_count);
    end
    clearInputs();
    trace_ready = 1'b1;
    guard = 0;
    while (!done && guard < 10) begin
      tick();
      guard++;
    end
    checks++;
    if (done !== 1'b1 || trace_valid !== 1'b0 || trace_data !== 72'h0 || timeout !== 1'b1) begin
      errors++; $display("FAIL to_done: got done=%0b v=%0b %h to=%0b want done=1 v=0 data=0 to=1",
                         done, trace_valid, trace_data, timeout);
    end

    // Second run: reset asynchronously while a record is still waiting in drain.
    doReset();
    repeat (49) tick();
    reg_write = 1; dest_reg = 4'd6; reg_value = 16'h0666; pc = 16'h0600;
    tick();
    clearInputs();
    tick();
    checks++;
    if (timeout !== 1'b1 || trace_valid !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL to_middrain_pre: got to=%0b v=%0b done=%0b want to=1 v=1 done=0",
                         timeout, trace_valid, done);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({trace_valid, trace_data, cycle_count, inst_count, drop_count, overflow, timeout, done} !== '0) begin
      errors++;
      $display("FAIL to_middrain_reset: got v=%0b d=%h cyc=%0d inst=%0d drop=%0d ov=%0b to=%0b done=%0b want all 0",
               trace_valid, trace_data, cycle_count, inst_count, drop_count, overflow, timeout, done);
    end
  endtask

  initial begin
    clearInputs();
    trace_ready = 1'b0;
    test_reset();
    test_basic();
    test_overflow();
    test_full_push_pop();
    test_store_and_reg();
    test_halt();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
